// File: rtl/ctrl_bus_pkg.sv
// Shared constants and types for the SOPC control-bus responder.
package ctrl_bus_pkg;

  localparam logic [7:0] ADDR_STATUS = 8'h10;
  localparam logic [7:0] ADDR_CTRL   = 8'h11;

  // Bit positions inside a write to ADDR_CTRL
  localparam int unsigned CTRL_CLR      = 0;
  localparam int unsigned CTRL_ABORT    = 1;
  localparam int unsigned CTRL_DONE_CLR = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } run_state_t;

endpackage

// File: rtl/ctrl_bus_slave_strobe_edge.sv
// Two-flop rising-edge detector for a software-toggled PIO strobe level.
module strobe_edge (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  output logic rise
);

  logic s_q;
  logic s_q2;

  // Sample the strobe and keep one cycle of history
  always_ff @(posedge clk) begin
    if (reset) begin
      s_q  <= 1'b0;
      s_q2 <= 1'b0;
    end else begin
      s_q  <= strobe;
      s_q2 <= s_q;
    end
  end

  assign rise = s_q & ~s_q2;

endmodule

// File: rtl/ctrl_bus_slave.sv
// Control-bus responder: byte register file, gate-length register and run controller.
module ctrl_bus_slave
  import ctrl_bus_pkg::*;
#(
  parameter int unsigned NCFG = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        addr_in,
  input  logic [7:0]        wdata_in,
  output logic [7:0]        rdata_out,
  input  logic              addr_write,
  input  logic              swrite,
  input  logic              sread,
  input  logic              cread,
  input  logic              swrite32,
  input  logic [31:0]       wdata32,
  output logic [31:0]       rdata32,
  input  logic              start_step,
  output logic              stop_step,
  output logic              gate,
  output logic              clr_counters,
  output logic [8*NCFG-1:0] cfg_out
);

  logic aw_edge, sw_edge, sr_edge, cr_edge, sw32_edge, st_edge;

  strobe_edge u_aw   (.clk(clk), .reset(reset), .strobe(addr_write), .rise(aw_edge));
  strobe_edge u_sw   (.clk(clk), .reset(reset), .strobe(swrite),     .rise(sw_edge));
  strobe_edge u_sr   (.clk(clk), .reset(reset), .strobe(sread),      .rise(sr_edge));
  strobe_edge u_cr   (.clk(clk), .reset(reset), .strobe(cread),      .rise(cr_edge));
  strobe_edge u_sw32 (.clk(clk), .reset(reset), .strobe(swrite32),   .rise(sw32_edge));
  strobe_edge u_st   (.clk(clk), .reset(reset), .strobe(start_step), .rise(st_edge));

  logic [7:0]        addr_q;
  logic [7:0]        acc_addr;
  logic [8*NCFG-1:0] cfg_q;
  logic [31:0]       gate_len;
  logic [31:0]       remaining;
  run_state_t        state;
  logic [7:0]        status;
  logic [7:0]        rd_data;
  logic              ctrl_wr;
  logic              abort;
  logic              done_clr;

  // An address strobe coinciding with a data strobe steers that access to the new address
  assign acc_addr = aw_edge ? addr_in : addr_q;
  assign ctrl_wr  = sw_edge && (acc_addr == ADDR_CTRL);
  assign abort    = ctrl_wr && wdata_in[CTRL_ABORT];
  assign done_clr = ctrl_wr && wdata_in[CTRL_DONE_CLR];
  assign status   = {5'b0, gate, state == DONE, state == RUN};
  assign cfg_out  = cfg_q;

  // Read mux: config registers, status, everything else reads zero
  always_comb begin
    rd_data = '0;
    if (acc_addr == ADDR_STATUS) rd_data = status;
    for (int unsigned i = 0; i < NCFG; i++) begin
      if (acc_addr == 8'(i)) rd_data = cfg_q[8*i +: 8];
    end
  end

  // Address latch
  always_ff @(posedge clk) begin
    if (reset) addr_q <= '0;
    else if (aw_edge) addr_q <= addr_in;
  end

  // Config register writes; RO and unmapped addresses fall through untouched
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q <= '0;
    end else if (sw_edge) begin
      for (int unsigned i = 0; i < NCFG; i++) begin
        if (acc_addr == 8'(i)) cfg_q[8*i +: 8] <= wdata_in;
      end
    end
  end

  // Byte read data register
  always_ff @(posedge clk) begin
    if (reset) rdata_out <= '0;
    else if (sr_edge) rdata_out <= rd_data;
  end

  // Gate length load and remaining-time snapshot
  always_ff @(posedge clk) begin
    if (reset) begin
      gate_len <= '0;
      rdata32  <= '0;
    end else begin
      if (sw32_edge) gate_len <= wdata32;
      if (cr_edge) rdata32 <= remaining;
    end
  end

  // Counter-bank clear pulse
  always_ff @(posedge clk) begin
    if (reset) clr_counters <= 1'b0;
    else clr_counters <= ctrl_wr && wdata_in[CTRL_CLR];
  end

  // Run controller with registered gate and stop_step; abort overrides everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      gate      <= 1'b0;
      stop_step <= 1'b0;
    end else if (abort) begin
      state     <= IDLE;
      remaining <= '0;
      gate      <= 1'b0;
      stop_step <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (st_edge) begin
            remaining <= gate_len;
            if (gate_len == '0) begin
              state     <= DONE;
              gate      <= 1'b0;
              stop_step <= 1'b1;
            end else begin
              state     <= RUN;
              gate      <= 1'b1;
              stop_step <= 1'b0;
            end
          end else if (state == DONE && done_clr) begin
            state     <= IDLE;
            stop_step <= 1'b0;
          end
        end
        RUN: begin
          remaining <= remaining - 32'd1;
          if (remaining == 32'd1) begin
            state     <= DONE;
            gate      <= 1'b0;
            stop_step <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          remaining <= '0;
          gate      <= 1'b0;
          stop_step <= 1'b0;
        end
      endcase
    end
  end

endmodule
